oc_add_norm: RTL and testbench

Sequential ones'-complement adder/subtractor for the result register path of the educational processor datapath. It accepts two N+1-bit ones'-complement operands on a start strobe and computes the sum or difference with an explicit end-around-carry cycle. It drives the result register value `rr` and its flags (overflow, zero, raw negative zero). Optionally, it normalizes a negative-zero result (all ones) to positive zero before completion. It is the producer side of the negative-zero indication: it creates, flags and optionally removes the all-ones pattern that downstream detection consumes.

---
 rtl/oc_add_norm.sv | 176 +++++++++++++++++
 tb/tb_oc_add_norm.sv | 243 ++++++++++++++++++++++++
 2 files changed

// File: rtl/oc_add_norm.sv
`default_nettype none
// ============================================================================
//  Module   : oc_add_norm
//  Purpose  : Sequential ones'-complement adder/subtractor for the result
//             register path. Each operation runs in three steps. The first
//             step is the raw sum. The second step is the end-around-carry
//             fold. An optional third step rewrites negative zero as
//             positive zero. The flags ovf, nz and zero are produced
//             together with the result.
//  Options  : `OC_NEG_ZERO_NORM_EN adds the NORM step. In that build an
//             all-ones (-0) result is cleared to +0 before completion.
//  Revision : 1.0 - initial release
// ============================================================================
module oc_add_norm #(
  parameter int N = 4
) (
  input  logic       clk,
  input  logic       rst_n,
  input  logic       start,
  input  logic       op,
  input  logic [N:0] a,
  input  logic [N:0] b,
  output logic       busy,
  output logic       done,
  output logic [N:0] rr,
  output logic       ovf,
  output logic       nz,
  output logic       zero
);

  // --------------------------------------------------------------------------
  // State encoding
  // --------------------------------------------------------------------------
  localparam logic [2:0] c_st_idle = 3'd0;
  localparam logic [2:0] c_st_sum  = 3'd1;
  localparam logic [2:0] c_st_eac  = 3'd2;
`ifdef OC_NEG_ZERO_NORM_EN
  localparam logic [2:0] c_st_norm = 3'd3;
`endif
  localparam logic [2:0] c_st_done = 3'd4;

  // --------------------------------------------------------------------------
  // Registers
  // --------------------------------------------------------------------------
  logic [2:0] r_state;
  logic [N:0] r_ra;      // latched operand A
  logic [N:0] r_rb;      // latched operand B, already inverted for subtract
  logic [N:0] r_s;       // raw sum bits from the SUM step
  logic       r_c;       // carry out of the SUM step, folded back in EAC
  logic [N:0] r_rr;
  logic       r_ovf;
  logic       r_nz;
  logic       r_zero;
  logic       r_busy;
  logic       r_done;

  // --------------------------------------------------------------------------
  // Combinational helpers
  // --------------------------------------------------------------------------
  logic [2:0]   w_next_state;
  logic [N+1:0] w_sum;       // {carry, sum} of the two latched operands
  logic [N:0]   w_eac;       // sum with the end-around carry added back
  logic [N:0]   w_b_eff;     // operand B as it enters the adder
  logic         w_eac_ones;  // folded result is all ones (-0)
  logic         w_eac_zero;  // folded result is all zeros (+0)

  assign w_b_eff    = op ? ~b : b;
  assign w_sum      = {1'b0, r_ra} + {1'b0, r_rb};
  assign w_eac      = r_s + {{N{1'b0}}, r_c};
  assign w_eac_ones = (w_eac == {(N+1){1'b1}});
  assign w_eac_zero = (w_eac == {(N+1){1'b0}});

  // Next-state decode. A start pulse is honoured only in IDLE, so a start
  // that arrives during an operation is dropped.
  always_comb begin
    w_next_state = r_state;
    case (r_state)
      c_st_idle: begin
        if (start) begin
          w_next_state = c_st_sum;
        end
      end
      c_st_sum: begin
        w_next_state = c_st_eac;
      end
      c_st_eac: begin
`ifdef OC_NEG_ZERO_NORM_EN
        w_next_state = c_st_norm;
`else
        w_next_state = c_st_done;
`endif
      end
`ifdef OC_NEG_ZERO_NORM_EN
      c_st_norm: begin
        w_next_state = c_st_done;
      end
`endif
      c_st_done: begin
        w_next_state = c_st_idle;
      end
      default: begin
        w_next_state = c_st_idle;
      end
    endcase
  end

  // State register plus registered busy/done. Both are derived from the next
  // state so they line up exactly with the state they describe.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_state <= c_st_idle;
      r_busy  <= 1'b0;
      r_done  <= 1'b0;
    end else begin
      r_state <= w_next_state;
      r_busy  <= (w_next_state != c_st_idle);
      r_done  <= (w_next_state == c_st_done);
    end
  end

  // Operand capture and raw sum. The inputs are only looked at on the
  // accepted start edge, so they are free to change afterwards.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_ra <= '0;
      r_rb <= '0;
      r_s  <= '0;
      r_c  <= 1'b0;
    end else begin
      if ((r_state == c_st_idle) && start) begin
        r_ra <= a;
        r_rb <= w_b_eff;
      end
      if (r_state == c_st_sum) begin
        r_s <= w_sum[N:0];
        r_c <= w_sum[N+1];
      end
    end
  end

  // Result and flags. They are written in EAC and, in the normalising build,
  // adjusted in NORM. They then hold until the next EAC. The nz flag keeps
  // reporting the raw -0 even after NORM clears rr.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_rr   <= '0;
      r_ovf  <= 1'b0;
      r_nz   <= 1'b0;
      r_zero <= 1'b0;
    end else begin
      if (r_state == c_st_eac) begin
        r_rr   <= w_eac;
        r_ovf  <= (r_ra[N] == r_rb[N]) && (w_eac[N] != r_ra[N]);
        r_nz   <= w_eac_ones;
        r_zero <= w_eac_zero || w_eac_ones;
      end
`ifdef OC_NEG_ZERO_NORM_EN
      if ((r_state == c_st_norm) && (r_rr == {(N+1){1'b1}})) begin
        r_rr <= '0;
      end
`endif
    end
  end

  // --------------------------------------------------------------------------
  // Outputs (all straight from flops)
  // --------------------------------------------------------------------------
  assign busy = r_busy;
  assign done = r_done;
  assign rr   = r_rr;
  assign ovf  = r_ovf;
  assign nz   = r_nz;
  assign zero = r_zero;

endmodule
`default_nettype wire

// File: tb/tb_oc_add_norm.sv
`default_nettype none
// ============================================================================
//  Module   : tb_oc_add_norm
//  Purpose  : Scoreboard bench for oc_add_norm. Expected results come from an
//             integer ones'-complement model and are queued at each start.
//             They are compared when done pulses. Honours
//             `OC_NEG_ZERO_NORM_EN for latency and -0 handling.
//  Revision : 1.0 - initial release
// ============================================================================
module tb_oc_add_norm;

  localparam int N    = 4;
  localparam int MAXU = (1 << (N + 1)) - 1;   // all-ones value, also the modulus
`ifdef OC_NEG_ZERO_NORM_EN
  localparam int LAT  = 4;
  localparam bit NORM = 1'b1;
`else
  localparam int LAT  = 3;
  localparam bit NORM = 1'b0;
`endif

  logic       clk = 1'b0;
  logic       rst_n;
  logic       start;
  logic       op;
  logic [N:0] a;
  logic [N:0] b;
  logic       busy;
  logic       done;
  logic [N:0] rr;
  logic       ovf;
  logic       nz;
  logic       zero;

  typedef struct packed {
    logic [N:0] rr;
    logic       ovf;
    logic       nz;
    logic       zero;
  } exp_t;

  exp_t exp_q[$];
  int   checks   = 0;
  int   errors   = 0;
  int   done_cnt = 0;

  oc_add_norm #(.N(N)) dut (
    .clk   (clk),
    .rst_n (rst_n),
    .start (start),
    .op    (op),
    .a     (a),
    .b     (b),
    .busy  (busy),
    .done  (done),
    .rr    (rr),
    .ovf   (ovf),
    .nz    (nz),
    .zero  (zero)
  );

  always #5 clk = ~clk;

  // Count every done pulse, sampled mid-cycle
  always @(negedge clk) begin
    if (done) done_cnt <= done_cnt + 1;
  end

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] expv);
    checks++;
    if (got !== expv) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h", tag, got, expv);
    end
  endtask

  function automatic int sval(input logic [N:0] x);
    logic [N:0] inv;
    inv = ~x;
    return x[N] ? -int'(inv) : int'(x);
  endfunction

  // Arithmetic model: sum modulo 2^(N+1)-1 (with all-ones kept as -0),
  // overflow from the signed integer value
  function automatic exp_t model(input logic [N:0] x, input logic [N:0] y, input logic o);
    logic [N:0] ye;
    int         s;
    int         t;
    exp_t       e;
    ye = o ? ~y : y;
    s  = int'(x) + int'(ye);
    if (s > MAXU) s = s - MAXU;
    t      = sval(x) + sval(ye);
    e.ovf  = (t > MAXU / 2) || (t < -(MAXU / 2));
    e.nz   = (s == MAXU);
    e.zero = (s == 0) || (s == MAXU);
    e.rr   = (NORM && s == MAXU) ? '0 : s[N:0];
    return e;
  endfunction

  task automatic drive_start(input logic [N:0] x, input logic [N:0] y, input logic o);
    @(negedge clk);
    a     = x;
    b     = y;
    op    = o;
    start = 1'b1;
    exp_q.push_back(model(x, y, o));
    @(posedge clk);
    #1;
    start = 1'b0;
    check("accepted", {31'd0, busy}, 32'd1);
    a  = (N+1)'($urandom);
    b  = (N+1)'($urandom);
    op = 1'($urandom);
  endtask

  // Wait for done; lat0 = edges already elapsed since the start edge (inclusive)
  task automatic wait_done(input string tag, input int lat0);
    int   lat;
    bit   seen;
    exp_t e;
    lat  = lat0;
    seen = 1'b0;
    while (!seen && lat < 20) begin
      @(posedge clk);
      #1;
      lat++;
      if (done) seen = 1'b1;
    end
    if (!seen) begin
      check({tag, "_timeout"}, {31'd0, done}, 32'd1);
      if (exp_q.size() > 0) void'(exp_q.pop_front());
      return;
    end
    check({tag, "_latency"}, lat, LAT);
    check({tag, "_busy"}, {31'd0, busy}, 32'd1);
    if (exp_q.size() == 0) begin
      check({tag, "_queue"}, 32'd0, 32'd1);
      return;
    end
    e = exp_q.pop_front();
    check({tag, "_rr"},   {27'd0, rr},   {27'd0, e.rr});
    check({tag, "_ovf"},  {31'd0, ovf},  {31'd0, e.ovf});
    check({tag, "_nz"},   {31'd0, nz},   {31'd0, e.nz});
    check({tag, "_zero"}, {31'd0, zero}, {31'd0, e.zero});
    @(posedge clk);
    #1;
    check({tag, "_idle_busy"}, {31'd0, busy}, 32'd0);
    check({tag, "_idle_done"}, {31'd0, done}, 32'd0);
  endtask

  task automatic run_op(input string tag, input logic [N:0] x, input logic [N:0] y, input logic o);
    drive_start(x, y, o);
    wait_done(tag, 1);
  endtask

  initial begin
    int dc;
    rst_n = 1'b0;
    start = 1'b0;
    op    = 1'b0;
    a     = '0;
    b     = '0;
    repeat (3) @(posedge clk);
    #1;
    check("rst_busy", {31'd0, busy}, 32'd0);
    check("rst_done", {31'd0, done}, 32'd0);
    check("rst_rr",   {27'd0, rr},   32'd0);
    check("rst_ovf",  {31'd0, ovf},  32'd0);
    check("rst_nz",   {31'd0, nz},   32'd0);
    check("rst_zero", {31'd0, zero}, 32'd0);
    @(negedge clk);
    rst_n = 1'b1;

    // Directed cases; each starts in the IDLE cycle right after the previous
    // DONE, which also exercises back-to-back acceptance
    run_op("add",     5'b00011, 5'b00100, 1'b0);
    run_op("sub_eac", 5'b00101, 5'b00011, 1'b1);
    run_op("negzero", 5'b00011, 5'b00011, 1'b1);
    run_op("mz_mz",   5'b11111, 5'b11111, 1'b0);
    run_op("sub_neg", 5'b00010, 5'b00101, 1'b1);
    run_op("zero",    5'b00000, 5'b00000, 1'b0);

    // start pulsed while busy must be ignored
    dc = done_cnt;
    drive_start(5'b00110, 5'b00001, 1'b0);
    @(negedge clk);
    a     = 5'b01010;
    b     = 5'b00101;
    op    = 1'b1;
    start = 1'b1;
    @(posedge clk);
    #1;
    start = 1'b0;
    wait_done("ignore", 2);
    repeat (8) @(posedge clk);
    #1;
    check("ignore_done_cnt", done_cnt - dc, 1);
    check("ignore_busy", {31'd0, busy}, 32'd0);

    // Overflow, then reset during EAC with nonzero outputs pending
    run_op("ovf", 5'b01100, 5'b01000, 1'b0);
    dc = done_cnt;
    drive_start(5'b00011, 5'b00100, 1'b0);
    @(posedge clk);
    #1;
    rst_n = 1'b0;
    #1;
    void'(exp_q.pop_back());
    check("mid_rst_busy", {31'd0, busy}, 32'd0);
    check("mid_rst_done", {31'd0, done}, 32'd0);
    check("mid_rst_rr",   {27'd0, rr},   32'd0);
    check("mid_rst_ovf",  {31'd0, ovf},  32'd0);
    check("mid_rst_nz",   {31'd0, nz},   32'd0);
    check("mid_rst_zero", {31'd0, zero}, 32'd0);
    repeat (3) @(posedge clk);
    @(negedge clk);
    rst_n = 1'b1;
    repeat (4) @(posedge clk);
    #1;
    check("mid_rst_no_done", done_cnt - dc, 0);
    run_op("after_rst", 5'b00001, 5'b00001, 1'b0);

    // Random operands
    for (int i = 0; i < 12; i++) begin
      run_op("rand", (N+1)'($urandom), (N+1)'($urandom), 1'($urandom));
    end

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

  // Absolute time guard
  initial begin
    #200000;
    errors++;
    $display("FAIL watchdog: got timeout expected completion");
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $fatal(1, "watchdog");
  end

endmodule
`default_nettype wire
